adc_acq_scheduler: RTL and testbench
====================================

// Module: adc_acq_scheduler
// PURPOSE
//  Periodic acquisition scheduler that drives the ADC control FSM.
//  - Issues one-cycle trigger pulses at a programmable period, for N frames or continuously.
//  - Waits for each conversion's done pulse before issuing the next trigger.
//  - Captures every ADC write strobe (data word + optional timestamp) into a FWFT FIFO for host/DMA readout.
//  - Sits between the register bank and the ADC control block, in the same clock domain.
// PARAMETERS
//  DW          32  sample word width (matches ADC data output)
//  FIFO_DEPTH  16  sample FIFO depth; power of 2, >= 4
//  TSW         32  timestamp width (used only with ADC_SCHED_TSTAMP_EN)
// PORTS
//  clk          in   1           system clock
//  rst          in   1           synchronous reset, active-high
//  start        in   1           pulse: begin acquisition (ignored while busy)
//  stop         in   1           pulse: end after current conversion completes
//  period       in   32          cycles from one trigger to the next; values < 2 act as 2
//  nframes      in   16          frames to run; 0 = continuous until stop
//  adc_trigger  out  1           one-cycle trigger to the ADC control block
//  adc_done     in   1           conversion-complete pulse from the ADC control block
//  adc_wr       in   1           sample-valid strobe from the ADC control block
//  adc_data     in   DW          sample word
//  rd_en        in   1           pop FIFO head
//  rd_data      out  DW          FIFO head word (FWFT)
//  rd_ts        out  TSW         FIFO head timestamp; 0 when the feature is compiled out
//  empty        out  1           FIFO empty
//  fifo_count   out  clog2+1     FIFO occupancy
//  busy         out  1           FSM not in IDLE
//  overflow     out  1           sticky: sample dropped on a full FIFO
//  overrun      out  1           sticky: a conversion outlasted its period
//  frame_cnt    out  16          frames completed since start
// BEHAVIOUR
//  Reset
//  - All outputs 0; empty=1; FSM returns to IDLE; FIFO is flushed.
//  - Reset mid-operation aborts immediately. No trigger is issued in the reset cycle or the cycle after it.
//  FSM states: IDLE, TRIG, CONV, HOLD, DONE
//  - IDLE: on start, clear frame_cnt, overflow and overrun, then go to TRIG. The FIFO is NOT flushed.
//  - TRIG: drive adc_trigger=1 for exactly one cycle, load period timer to 0, go to CONV.
//  - CONV: period timer increments each cycle.
//      On adc_done: frame_cnt++, then:
//      - last frame (frame_cnt+1 == nframes, nframes != 0) or stop seen -> DONE;
//      - else timer >= period-1 -> set overrun, go directly to TRIG;
//      - else -> HOLD.
//  - HOLD: when timer >= period-1, go to TRIG; a pending stop goes to DONE instead.
//  - DONE: single cycle, then IDLE; busy drops as IDLE is entered.
//  Stop handling
//  - A stop in any busy state is latched until DONE.
//  - A stop in IDLE has no effect.
//  - start and stop in the same IDLE cycle: stop wins, start is ignored.
//  Nominal timing: trigger-to-trigger spacing is exactly period cycles while conversion time <= period-1.
//  FIFO
//  - Writes on adc_wr in any state, including IDLE, so trailing samples are kept.
//  - Full and no rd_en: the sample is dropped and overflow is set.
//  - Full with rd_en and adc_wr together: both succeed; count is unchanged.
//  - rd_en while empty is ignored.
//  - rd_data/rd_ts are valid whenever empty=0; a pop updates them on the next cycle.
//  - Pointers wrap modulo FIFO_DEPTH; fifo_count saturates at FIFO_DEPTH.
// CONFIGURATION
//  ADC_SCHED_TSTAMP_EN
//  - Defined: a free-running TSW-bit timestamp counter (cleared by rst, wraps) is stored with each sample; rd_ts shows the head entry's value.
//  - Undefined: no timestamp counter or storage; rd_ts is tied to 0.
// STRUCTURE
//  Package adc_sched_pkg:
//  - FSM state encoding localparams;
//  - MIN_PERIOD = 2;
//  - FIFO address width function clog2.
//  Sub-module sync_fifo_fwft (width DW [+TSW], depth FIFO_DEPTH):
//  - holds count/full/empty logic and wrap-around;
//  - the top level holds the FSM and the timers.
// TESTING
//  1. period=10, nframes=3, done 4 cycles after each trigger -> triggers at t0, t0+10, t0+20; frame_cnt=3; busy low; overrun=0.
//  2. period=5, done 8 cycles after each trigger -> overrun=1; each next trigger follows done by 1 cycle (TRIG entered on the done cycle, trigger asserted the cycle after).
//  3. nframes=0, stop asserted during CONV of frame 4 -> frame 4 completes, no 5th trigger, frame_cnt=4.
//  4. 20 adc_wr strobes with FIFO_DEPTH=16 and no reads -> fifo_count=16, overflow=1, head=first word; 16 pops drain in order and empty=1.
//  5. FIFO full, rd_en and adc_wr in the same cycle -> count stays 16, new word is at the tail, no overflow set.
//  6. rst asserted during HOLD -> next cycle busy=0, empty=1, adc_trigger stays 0; start afterwards runs normally.

Source files
------------

// File: rtl/adc_acq_scheduler_pkg.sv
// adc_sched_pkg: FSM encoding, timing constants and sizing helper shared by adc_acq_scheduler
package adc_sched_pkg;
   localparam logic [2:0] ST_IDLE = 3'd0, ST_TRIG = 3'd1, ST_CONV = 3'd2, ST_HOLD = 3'd3, ST_DONE = 3'd4;
   typedef enum logic [2:0] {
      IDLE = ST_IDLE,
      TRIG = ST_TRIG,
      CONV = ST_CONV,
      HOLD = ST_HOLD,
      DONE = ST_DONE
   } state_t;
   localparam int MIN_PERIOD = 2;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/adc_acq_scheduler_if.sv
// adc_acq_scheduler_if: trigger/done/sample bus between the scheduler (master) and the ADC control block (slave)
interface adc_acq_scheduler_if #(parameter int DW = 32);
   logic adc_trigger;
   logic adc_done;
   logic adc_wr;
   logic [DW-1:0] adc_data;
   modport master (output adc_trigger, input adc_done, adc_wr, adc_data);
   modport slave (input adc_trigger, output adc_done, adc_wr, adc_data);
endinterface

// File: rtl/adc_acq_scheduler_fifo.sv
// sync_fifo_fwft: first-word-fall-through sample FIFO; a write on a full FIFO is dropped unless a pop frees the slot
module sync_fifo_fwft import adc_sched_pkg::*; #(
   parameter int W = 32,
   parameter int DEPTH = 16,
   localparam int AW = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr,
   input  logic          rd,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          empty,
   output logic          drop,
   output logic [AW:0]   count
);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic full, push, pop;
   assign empty = count == '0;
   assign full = count == (AW+1)'(DEPTH);
   assign pop = rd && !empty;
   assign push = wr && (!full || pop);
   assign drop = wr && !push;
   assign dout = mem[rp];
   always_ff @(posedge clk)
      if (push) mem[wp] <= din;
   always_ff @(posedge clk)
      if (rst) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         wp <= wp + AW'(push);
         rp <= rp + AW'(pop);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
endmodule

// File: rtl/adc_acq_scheduler.sv
// adc_acq_scheduler: periodic ADC trigger scheduler with sample capture FIFO
// ADC_SCHED_TSTAMP_EN: when defined, a free-running timestamp is stored with each sample
module adc_acq_scheduler import adc_sched_pkg::*; #(
   parameter int DW = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int TSW = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        stop,
   input  logic [31:0]                 period,
   input  logic [15:0]                 nframes,
   adc_acq_scheduler_if.master         adc,
   input  logic                        rd_en,
   output logic [DW-1:0]               rd_data,
   output logic [TSW-1:0]              rd_ts,
   output logic                        empty,
   output logic [clog2(FIFO_DEPTH):0]  fifo_count,
   output logic                        busy,
   output logic                        overflow,
   output logic                        overrun,
   output logic [15:0]                 frame_cnt
);
   state_t state;
   logic [31:0] timer, plen;
   logic stop_q, stop_seen, expire, last, go, drop, trig;
   assign plen = period < 32'(MIN_PERIOD) ? 32'(MIN_PERIOD) : period;
   // timer counts cycles since the trigger, so expiry at plen-1 re-triggers exactly plen cycles later
   assign expire = timer >= plen - 32'd1;
   assign stop_seen = stop_q || stop;
   assign last = nframes != '0 && frame_cnt + 16'd1 == nframes;
   assign go = state == IDLE && start && !stop;
   assign adc.adc_trigger = trig;
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         trig <= 1'b0;
         busy <= 1'b0;
         stop_q <= 1'b0;
         overrun <= 1'b0;
         frame_cnt <= '0;
         timer <= '0;
      end else begin
         trig <= 1'b0;
         timer <= timer + 32'(timer != '1);
         if (stop && state != IDLE) stop_q <= 1'b1;
         case (state)
            IDLE: if (go) begin
               state <= TRIG;
               trig <= 1'b1;
               busy <= 1'b1;
               timer <= '0;
               stop_q <= 1'b0;
               overrun <= 1'b0;
               frame_cnt <= '0;
            end
            TRIG: state <= CONV;
            CONV: if (adc.adc_done) begin
               frame_cnt <= frame_cnt + 16'd1;
               if (last || stop_seen) state <= DONE;
               else if (expire) begin
                  overrun <= 1'b1;
                  state <= TRIG;
                  trig <= 1'b1;
                  timer <= '0;
               end else state <= HOLD;
            end
            HOLD: if (expire) begin
               if (stop_seen) state <= DONE;
               else begin
                  state <= TRIG;
                  trig <= 1'b1;
                  timer <= '0;
               end
            end
            default: begin
               state <= IDLE;
               busy <= 1'b0;
               stop_q <= 1'b0;
            end
         endcase
      end
   always_ff @(posedge clk)
      if (rst) overflow <= 1'b0;
      else overflow <= (overflow && !go) || drop;
`ifdef ADC_SCHED_TSTAMP_EN
   localparam int FW = DW + TSW;
   logic [TSW-1:0] ts;
   logic [FW-1:0] head;
   always_ff @(posedge clk)
      if (rst) ts <= '0;
      else ts <= ts + TSW'(1);
   assign {rd_ts, rd_data} = head;
   sync_fifo_fwft #(.W(FW), .DEPTH(FIFO_DEPTH)) fifo (
      .clk, .rst, .wr(adc.adc_wr), .rd(rd_en), .din({ts, adc.adc_data}),
      .dout(head), .empty, .drop, .count(fifo_count)
   );
`else
   assign rd_ts = '0;
   sync_fifo_fwft #(.W(DW), .DEPTH(FIFO_DEPTH)) fifo (
      .clk, .rst, .wr(adc.adc_wr), .rd(rd_en), .din(adc.adc_data),
      .dout(rd_data), .empty, .drop, .count(fifo_count)
   );
`endif
endmodule

// File: tb/tb_adc_acq_scheduler.sv
// tb_adc_acq_scheduler: table, directed and randomized checks of adc_acq_scheduler against a behavioural model
module tb_adc_acq_scheduler;
   logic clk = 0, rst = 1, start = 0, stop = 0, rd_en = 0;
   logic [31:0] period = 32'd10;
   logic [15:0] nframes = 16'd1;
   logic [31:0] rd_data, rd_ts;
   logic empty, busy, overflow, overrun;
   logic [4:0] fifo_count;
   logic [15:0] frame_cnt;
   logic m_done = 0, m_wr = 0, man_wr = 0;
   logic [31:0] m_data = 0, man_data = 0;
   int nvec = 0, nmis = 0, cyc = 0, cd = 0, dly = 1;
   int trigs[$];
   logic [31:0] q[$];
   bit ovf_m = 0;
   typedef struct {
      logic [31:0] per;
      logic [15:0] nf;
      int d;
      int sp;
      int fr;
      bit ovr;
   } vec_t;
   vec_t tbl[6];

   adc_acq_scheduler_if #(.DW(32)) bus();
   assign bus.adc_done = m_done;
   assign bus.adc_wr = m_wr | man_wr;
   assign bus.adc_data = m_wr ? m_data : man_data;

   adc_acq_scheduler #(.DW(32), .FIFO_DEPTH(16), .TSW(32)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .period(period), .nframes(nframes),
      .adc(bus), .rd_en(rd_en), .rd_data(rd_data), .rd_ts(rd_ts), .empty(empty),
      .fifo_count(fifo_count), .busy(busy), .overflow(overflow), .overrun(overrun), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // reference FIFO: holds up to 16 words, anything beyond is lost and flags overflow
   task automatic mpush(input logic [31:0] w);
      if (q.size() < 16) q.push_back(w);
      else ovf_m = 1;
   endtask

   // one clock; the ADC model answers each trigger with done+sample dly cycles later
   task automatic tick;
      @(posedge clk);
      #1;
      cyc++;
      start = 0; stop = 0; rd_en = 0; man_wr = 0; m_done = 0; m_wr = 0;
      if (cd > 0) begin
         cd--;
         if (cd == 0) begin
            m_done = 1;
            m_wr = 1;
            m_data = $urandom;
            mpush(m_data);
         end
      end
      if (bus.adc_trigger === 1'b1) begin
         trigs.push_back(cyc);
         cd = dly;
      end
   endtask

   task automatic drain;
      int budget = 40;
      logic [31:0] e;
      while (empty === 1'b0 && budget > 0) begin
         e = 'x;
         if (q.size() > 0) e = q.pop_front();
         chk("rd_data", rd_data, e);
         rd_en = 1;
         tick;
         budget--;
      end
      chk("drain_empty", empty, 1);
      chk("model_left", q.size(), 0);
   endtask

   task automatic run_job(input logic [31:0] per, input logic [15:0] nf, input int d, input int stop_at);
      int budget = 2000;
      int since = -1;
      period = per; nframes = nf; dly = d;
      trigs.delete();
      ovf_m = 0;
      start = 1;
      tick;
      while (busy === 1'b1 && budget > 0) begin
         if (stop_at > 0 && trigs.size() == stop_at) begin
            since++;
            if (since == 2) stop = 1;
         end
         tick;
         budget--;
      end
      chk("job_timeout", budget > 0, 1);
   endtask

   task automatic check_job(input int sp, input int fr, input bit ovr);
      chk("trig_count", trigs.size(), fr);
      for (int i = 1; i < trigs.size(); i++) chk("spacing", trigs[i] - trigs[i-1], sp);
      chk("frame_cnt", frame_cnt, fr);
      chk("overrun", overrun, ovr);
      chk("busy_end", busy, 0);
      chk("overflow", overflow, ovf_m);
      drain();
   endtask

   initial begin
      int raw, p, d, n;
      logic [31:0] w;
      tbl[0] = '{32'd10, 16'd3, 4, 10, 3, 1'b0};
      tbl[1] = '{32'd5, 16'd3, 8, 9, 3, 1'b1};
      tbl[2] = '{32'd0, 16'd2, 3, 4, 2, 1'b1};
      tbl[3] = '{32'd1, 16'd3, 1, 2, 3, 1'b1};
      tbl[4] = '{32'd7, 16'd4, 2, 7, 4, 1'b0};
      tbl[5] = '{32'd3, 16'd5, 5, 6, 5, 1'b1};
      rst = 1;
      tick;
      tick;
      rst = 0;
      tick;
      chk("rst_busy", busy, 0);
      chk("rst_empty", empty, 1);
      chk("rst_count", fifo_count, 0);
      chk("rst_trigger", bus.adc_trigger, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
`ifndef ADC_SCHED_TSTAMP_EN
      chk("rst_ts", rd_ts, 0);
`endif
      start = 1; stop = 1;
      tick;
      tick;
      chk("start_stop_busy", busy, 0);
      chk("start_stop_trig", trigs.size(), 0);
      stop = 1;
      tick;
      for (int i = 0; i < 6; i++) begin
         run_job(tbl[i].per, tbl[i].nf, tbl[i].d, 0);
         check_job(tbl[i].sp, tbl[i].fr, tbl[i].ovr);
      end
      run_job(32'd10, 16'd0, 6, 4);
      check_job(10, 4, 0);
      for (int i = 0; i < 16; i++) begin
         man_wr = 1; man_data = $urandom; mpush(man_data);
         tick;
      end
      chk("full_count", fifo_count, 16);
      chk("full_overflow", overflow, 0);
      chk("full_head", rd_data, q[0]);
      w = q.pop_front();
      w = $urandom;
      rd_en = 1; man_wr = 1; man_data = w; mpush(w);
      tick;
      chk("rdwr_count", fifo_count, 16);
      chk("rdwr_overflow", overflow, 0);
      drain();
      for (int i = 0; i < 20; i++) begin
         man_wr = 1; man_data = $urandom; mpush(man_data);
         tick;
      end
      chk("ovf_count", fifo_count, 16);
      chk("ovf_flag", overflow, ovf_m);
      chk("ovf_head", rd_data, q[0]);
      drain();
      period = 32'd20; nframes = 16'd0; dly = 2;
      start = 1;
      tick;
      for (int i = 0; i < 5; i++) tick;
      chk("hold_busy", busy, 1);
      rst = 1; cd = 0;
      tick;
      rst = 0;
      q.delete();
      ovf_m = 0;
      chk("hrst_busy", busy, 0);
      chk("hrst_empty", empty, 1);
      chk("hrst_trig0", bus.adc_trigger, 0);
      tick;
      chk("hrst_trig1", bus.adc_trigger, 0);
      run_job(32'd10, 16'd3, 4, 0);
      check_job(10, 3, 0);
      for (int r = 0; r < 10; r++) begin
         raw = $urandom_range(0, 12);
         p = raw < 2 ? 2 : raw;
         if (p >= 3 && $urandom_range(0, 1) == 1) d = $urandom_range(1, p - 2);
         else d = $urandom_range(p, p + 6);
         n = $urandom_range(1, 20);
         run_job(32'(raw), 16'(n), d, 0);
         check_job(d < p - 1 ? p : d + 1, n, d >= p - 1);
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
